// File: rtl/aqed_fc_monitor.sv
`default_nettype none
// ============================================================================
// Module      : aqed_fc_monitor
// Description : A-QED functional-consistency monitor for the memory-core
//               double-buffer formal harness. Tracks per-frame write/read
//               counts, exposes resource-allow outputs, captures an
//               original/duplicate write pair and compares the data the
//               memory core returns for each of them.
// Revision    : 1.0 - initial release
// ============================================================================
module aqed_fc_monitor #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [CNT_W-1:0]  depth,
    input  logic              wen_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ren_in,
    input  logic              valid_out,
    input  logic [DATA_W-1:0] data_out,
    input  logic              exec_orig,
    input  logic              exec_dup,
    output logic              wen_allow,
    output logic              ren_allow,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              qed_done,
    output logic              qed_check
);

    // Saturation value of the global transaction indices
    localparam logic [IDX_W-1:0] c_IDX_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ORIG = 2'd1,
        S_DUP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  r_count_wen;
    logic [CNT_W-1:0]  r_count_ren;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [IDX_W-1:0]  r_w_idx;
    logic [IDX_W-1:0]  r_r_idx;
    state_t            r_state;
    logic [DATA_W-1:0] r_orig_data;
    logic [IDX_W-1:0]  r_orig_idx;
    logic [IDX_W-1:0]  r_dup_idx;
    logic              r_got_o;
    logic              r_got_d;
    logic [DATA_W-1:0] r_out_o;
    logic [DATA_W-1:0] r_out_d;
    logic              r_qed_done;
    logic              r_qed_check;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              w_wen_acc;
    logic              w_ren_acc;
    logic [CNT_W-1:0]  w_count_wen_nxt;
    logic [CNT_W-1:0]  w_count_ren_nxt;
    logic              w_frame_end;
    logic              w_latch_o;
    logic              w_latch_d;
    logic              w_have_o;
    logic              w_have_d;
    logic [IDX_W-1:0]  w_orig_idx_eff;
    logic [IDX_W-1:0]  w_dup_idx_eff;
    logic              w_rd_ok;
    logic              w_cap_o;
    logic              w_cap_d;

    // Resource allows come straight from the live counters
    assign wen_allow = (r_count_wen < depth);
    assign ren_allow = (r_count_ren < depth);

    // A beat is only counted when the corresponding allow is high
    assign w_wen_acc = wen_in & wen_allow;
    assign w_ren_acc = ren_in & ren_allow;

    assign w_count_wen_nxt = r_count_wen + CNT_W'(w_wen_acc);
    assign w_count_ren_nxt = r_count_ren + CNT_W'(w_ren_acc);

    // Frame closes when both post-update counts sit at depth, whichever
    // side got there first
    assign w_frame_end = (w_count_wen_nxt == depth) && (w_count_ren_nxt == depth);

    // Original is taken from the first tagged write seen while idle; the
    // duplicate must carry the same data and must not also be tagged
    // original (exec_orig takes priority and only acts in IDLE)
    assign w_latch_o = (r_state == S_IDLE) && w_wen_acc && exec_orig;
    assign w_latch_d = (r_state == S_ORIG) && w_wen_acc && exec_dup && !exec_orig
                       && (data_in == r_orig_data);

    // Index being latched this cycle is already eligible for capture
    assign w_have_o       = (r_state != S_IDLE) || w_latch_o;
    assign w_have_d       = (r_state == S_DUP) || (r_state == S_DONE) || w_latch_d;
    assign w_orig_idx_eff = w_latch_o ? r_w_idx : r_orig_idx;
    assign w_dup_idx_eff  = w_latch_d ? r_w_idx : r_dup_idx;

    // A saturated read index can no longer identify a unique beat
    assign w_rd_ok = valid_out && (r_r_idx != c_IDX_MAX);
    assign w_cap_o = w_rd_ok && w_have_o && !r_got_o && (r_r_idx == w_orig_idx_eff);
    assign w_cap_d = w_rd_ok && w_have_d && !r_got_d && (r_r_idx == w_dup_idx_eff);

    // ------------------------------------------------------------------
    // Per-frame write/read counters and completed-frame count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count_wen <= '0;
            r_count_ren <= '0;
            r_frame_cnt <= '0;
        end else if (clk_en) begin
            if (w_frame_end) begin
                r_count_wen <= '0;
                r_count_ren <= '0;
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end else begin
                r_count_wen <= w_count_wen_nxt;
                r_count_ren <= w_count_ren_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating global write/read transaction indices
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w_idx <= '0;
            r_r_idx <= '0;
        end else if (clk_en) begin
            if (w_wen_acc && (r_w_idx != c_IDX_MAX)) begin
                r_w_idx <= r_w_idx + IDX_W'(1);
            end
            if (valid_out && (r_r_idx != c_IDX_MAX)) begin
                r_r_idx <= r_r_idx + IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output capture for the original and duplicate read beats
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_got_o <= 1'b0;
            r_got_d <= 1'b0;
            r_out_o <= '0;
            r_out_d <= '0;
        end else if (clk_en) begin
            if (w_cap_o) begin
                r_got_o <= 1'b1;
                r_out_o <= data_out;
            end
            if (w_cap_d) begin
                r_got_d <= 1'b1;
                r_out_d <= data_out;
            end
        end
    end

    // ------------------------------------------------------------------
    // Orig/dup tracking FSM with registered done/check outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_orig_data <= '0;
            r_orig_idx  <= '0;
            r_dup_idx   <= '0;
            r_qed_done  <= 1'b0;
            r_qed_check <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (w_latch_o) begin
                        r_orig_data <= data_in;
                        r_orig_idx  <= r_w_idx;
                        r_state     <= S_ORIG;
                    end
                end
                S_ORIG: begin
                    if (w_latch_d) begin
                        r_dup_idx <= r_w_idx;
                        r_state   <= S_DUP;
                    end
                end
                S_DUP: begin
                    // Done is flagged one cycle after both captures exist
                    if (r_got_o && r_got_d) begin
                        r_qed_done  <= 1'b1;
                        r_qed_check <= (r_out_o == r_out_d);
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign qed_done  = r_qed_done;
    assign qed_check = r_qed_check;

endmodule
`default_nettype wire

// File: tb/tb_aqed_fc_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_aqed_fc_monitor
// Description : Self-checking bench for aqed_fc_monitor. A transaction-log
//               model (write/read logs indexed by global beat number) predicts
//               every output each cycle; directed sequences add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aqed_fc_monitor;

    localparam int DATA_W  = 16;
    localparam int CNT_W   = 8;
    localparam int IDX_W   = 6;
    localparam int IDX_MAX = (1 << IDX_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              clk_en;
    logic [CNT_W-1:0]  depth;
    logic              wen_in;
    logic [DATA_W-1:0] data_in;
    logic              ren_in;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              exec_orig;
    logic              exec_dup;
    logic              wen_allow;
    logic              ren_allow;
    logic [CNT_W-1:0]  frame_cnt;
    logic              qed_done;
    logic              qed_check;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                m_cw, m_cr, m_frames, m_widx, m_ridx, m_oi, m_di;
    logic [DATA_W-1:0] m_od;
    bit                m_done, m_check;
    logic [DATA_W-1:0] wmem [int];
    logic [DATA_W-1:0] rdlog[int];

    // Random-phase scratch
    bit                s_en, s_w, s_r, s_v, s_eo, s_ed, s_acc;
    logic [DATA_W-1:0] s_di, s_do;

    always #5 clk = ~clk;

    aqed_fc_monitor #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .depth    (depth),
        .wen_in   (wen_in),
        .data_in  (data_in),
        .ren_in   (ren_in),
        .valid_out(valid_out),
        .data_out (data_out),
        .exec_orig(exec_orig),
        .exec_dup (exec_dup),
        .wen_allow(wen_allow),
        .ren_allow(ren_allow),
        .frame_cnt(frame_cnt),
        .qed_done (qed_done),
        .qed_check(qed_check)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cw = 0; m_cr = 0; m_frames = 0; m_widx = 0; m_ridx = 0;
        m_oi = -1; m_di = -1; m_od = '0; m_done = 0; m_check = 0;
        wmem.delete();
        rdlog.delete();
    endtask

    // One enabled clock of the log-based model
    task automatic model_step();
        int d;
        bit aw, ar;
        d  = int'(depth);
        aw = wen_in && (m_cw < d);
        ar = ren_in && (m_cr < d);
        // Verdict uses data already captured before this edge
        if (!m_done && m_oi >= 0 && m_di >= 0 && m_oi < IDX_MAX && m_di < IDX_MAX
            && rdlog.exists(m_oi) && rdlog.exists(m_di)) begin
            m_done  = 1;
            m_check = (rdlog[m_oi] == rdlog[m_di]);
        end
        if (valid_out && m_ridx < IDX_MAX) begin
            rdlog[m_ridx] = data_out;
            m_ridx++;
        end
        if (aw) begin
            if (m_oi < 0 && exec_orig) begin
                m_oi = m_widx;
                m_od = data_in;
            end else if (m_oi >= 0 && m_di < 0 && exec_dup && !exec_orig && data_in == m_od) begin
                m_di = m_widx;
            end
            if (m_widx < IDX_MAX) begin
                wmem[m_widx] = data_in;
                m_widx++;
            end
        end
        if (aw) m_cw++;
        if (ar) m_cr++;
        if (m_cw == d && m_cr == d) begin
            m_cw = 0;
            m_cr = 0;
            m_frames++;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_clear();
        else if (clk_en) model_step();
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            chk("wen_allow", int'(wen_allow), int'(m_cw < int'(depth)));
            chk("ren_allow", int'(ren_allow), int'(m_cr < int'(depth)));
            chk("frame_cnt", int'(frame_cnt), m_frames % (1 << CNT_W));
            chk("qed_done",  int'(qed_done),  int'(m_done));
            chk("qed_check", int'(qed_check), int'(m_check));
        end
    end

    task automatic idle();
        wen_in = 0; data_in = '0; ren_in = 0; valid_out = 0;
        data_out = '0; exec_orig = 0; exec_dup = 0;
    endtask

    task automatic cyc(input bit w, input logic [DATA_W-1:0] di, input bit eo, input bit ed,
                       input bit r, input bit v, input logic [DATA_W-1:0] dout);
        wen_in = w; data_in = di; exec_orig = eo; exec_dup = ed;
        ren_in = r; valid_out = v; data_out = dout;
        @(posedge clk);
        #2;
        idle();
    endtask

    task automatic do_reset(input int d);
        reset = 1; clk_en = 1; depth = CNT_W'(d);
        idle();
        repeat (2) @(posedge clk);
        #2;
        reset = 0;
    endtask

    function automatic logic [DATA_W-1:0] pair_data(input int i);
        return (i == 1 || i == 5) ? 16'h00AA : 16'h0011 + 16'(i);
    endfunction

    // Eight writes (orig at idx 1, dup at idx 5), optional reads back
    task automatic qed_writes();
        for (int i = 0; i < 8; i++)
            cyc(1, pair_data(i), i == 1, i == 5, 0, 0, '0);
    endtask

    task automatic qed_reads(input int n, input logic [DATA_W-1:0] r5val);
        for (int i = 0; i < n; i++)
            cyc(0, '0, 0, 0, 1, 1, (i == 5) ? r5val : pair_data(i));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset state, depth 4 interleaved ----
        do_reset(4);
        chk("rst_wen_allow", int'(wen_allow), 1);
        chk("rst_ren_allow", int'(ren_allow), 1);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_qed_done",  int'(qed_done),  0);
        chk("rst_qed_check", int'(qed_check), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 16'h0030 + 16'(i), 0, 0, 0, 0, '0);
            if (i == 3) begin
                chk("d4_wen_full", int'(wen_allow), 0);
                chk("d4_ren_open", int'(ren_allow), 1);
            end
            cyc(0, '0, 0, 0, 1, 1, 16'h0030 + 16'(i));
        end
        chk("d4_frame_cnt", int'(frame_cnt), 1);
        chk("d4_wen_allow", int'(wen_allow), 1);
        chk("d4_ren_allow", int'(ren_allow), 1);

        // ---- depth 3, writes first then reads ----
        do_reset(3);
        for (int i = 0; i < 3; i++) cyc(1, 16'h0040, 0, 0, 0, 0, '0);
        chk("d3_wen_full", int'(wen_allow), 0);
        cyc(1, 16'h0041, 0, 0, 0, 0, '0);
        chk("d3_extra_ignored", int'(wen_allow), 0);
        chk("d3_no_frame", int'(frame_cnt), 0);
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 0, 1, 0, '0);
        chk("d3_frame_cnt", int'(frame_cnt), 1);
        chk("d3_wen_reopen", int'(wen_allow), 1);

        // ---- matching pair ----
        do_reset(16);
        qed_writes();
        qed_reads(8, 16'h00AA);
        chk("pass_done",  int'(qed_done),  1);
        chk("pass_check", int'(qed_check), 1);

        // ---- mismatching returned data ----
        do_reset(16);
        qed_writes();
        qed_reads(8, 16'h00AB);
        chk("fail_done",  int'(qed_done),  1);
        chk("fail_check", int'(qed_check), 0);

        // ---- dup with different data is ignored ----
        do_reset(16);
        for (int i = 0; i < 8; i++)
            cyc(1, (i == 5) ? 16'h0055 : pair_data(i), i == 1, i == 5, 0, 0, '0);
        for (int i = 0; i < 8; i++)
            cyc(0, '0, 0, 0, 1, 1, (i == 5) ? 16'h0055 : pair_data(i));
        cyc(0, '0, 0, 0, 0, 0, '0);
        chk("nodup_done", int'(qed_done), 0);

        // ---- reset in DUP after the original was captured ----
        do_reset(16);
        qed_writes();
        qed_reads(2, 16'h00AA);
        reset = 1;
        #1;
        chk("midrst_done",      int'(qed_done),  0);
        chk("midrst_check",     int'(qed_check), 0);
        chk("midrst_frame",     int'(frame_cnt), 0);
        chk("midrst_wen_allow", int'(wen_allow), 1);
        @(posedge clk);
        #2;
        reset = 0;
        qed_writes();
        qed_reads(8, 16'h00AA);
        chk("post_rst_done",  int'(qed_done),  1);
        chk("post_rst_check", int'(qed_check), 1);

        // ---- randomized traffic against the model (indices saturate) ----
        for (int round = 0; round < 4; round++) begin
            do_reset($urandom_range(1, 5));
            for (int c = 0; c < 400; c++) begin
                s_en  = ($urandom_range(0, 9) != 0);
                s_w   = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 3))
                    0: s_di = 16'h00AA;
                    1: s_di = 16'h0055;
                    2: s_di = 16'h00AB;
                    default: s_di = 16'($urandom_range(0, 65535));
                endcase
                s_eo  = ($urandom_range(0, 9) == 0);
                s_ed  = ($urandom_range(0, 3) == 0);
                s_acc = s_w && (m_cw < int'(depth));
                s_r   = (m_cr < int'(depth)) && ($urandom_range(0, 1) == 1);
                s_v   = ((m_ridx < m_widx) || (m_ridx == m_widx && s_acc))
                        && ($urandom_range(0, 1) == 1);
                s_do  = (m_ridx < m_widx && wmem.exists(m_ridx)) ? wmem[m_ridx] : s_di;
                if ($urandom_range(0, 7) == 0) s_do = s_do ^ 16'h0001;
                clk_en = s_en;
                cyc(s_w, s_di, s_eo, s_ed, s_r, s_v, s_do);
            end
            clk_en = 1;
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
